// File: rtl/seg_bcd_scan_counter.sv
// Multi-digit BCD up/down counter with valid/ready load, wrap pulse and a scanned 7-segment driver.
// Latency: count/wrap 1 cycle after tick or load; seg/dig_sel 1 cycle after count/scan index.
// Backpressure: ld_ready is held low only in reset. Optional leading-zero blanking via SEG_LZ_BLANK_EN.
module seg_bcd_scan_counter #(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_CYCLES = 13500000,
    parameter int SCAN_CYCLES = 13500,
    parameter int SEG_INV     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [4*NUM_DIGITS-1:0] ld_data,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    wrap,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_sel
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0]            SEG_OFF = (SEG_INV != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (SEG_INV != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [PW-1:0]         presc;
    logic [SW-1:0]         scan_cnt;
    logic [IW-1:0]         scan_idx;
    logic                  tick;
    logic                  load;
    logic                  carry_out;
    logic [W-1:0]          step_cnt;
    logic [W-1:0]          ld_clamped;
    logic [3:0]            sel_nib;
    logic [6:0]            seg_raw;
    logic [NUM_DIGITS-1:0] onehot;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    assign tick = en && (presc == PW'(TICK_CYCLES - 1));
    assign load = ld_valid && ld_ready;

    // Ripple step: carry (up) or borrow (down) propagates while digits sit at their limit.
    always_comb begin
        logic [3:0] nib;
        logic       c;
        nib      = '0;
        c        = 1'b1;
        step_cnt = count;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nib = count[4*k +: 4];
            if (c) begin
                if (up) begin
                    if (nib >= 4'd9) begin
                        step_cnt[4*k +: 4] = 4'd0;
                    end else begin
                        step_cnt[4*k +: 4] = nib + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (nib == 4'd0) begin
                        step_cnt[4*k +: 4] = 4'd9;
                    end else begin
                        step_cnt[4*k +: 4] = nib - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        carry_out = c;
    end

    always_comb begin
        ld_clamped = ld_data;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (ld_data[4*k +: 4] > 4'd9) begin
                ld_clamped[4*k +: 4] = 4'd9;
            end
        end
    end

    always_comb begin
        sel_nib = '0;
        onehot  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            onehot[k] = (scan_idx == IW'(k));
            if (scan_idx == IW'(k)) begin
                sel_nib = count[4*k +: 4];
            end
        end
    end

`ifdef SEG_LZ_BLANK_EN
    logic sel_blank;

    // Scan from the top digit down; a digit is blank while it and everything above it is zero.
    always_comb begin
        logic hi_zero;
        hi_zero   = 1'b1;
        sel_blank = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            hi_zero = hi_zero && (count[4*k +: 4] == 4'd0);
            if (scan_idx == IW'(k)) begin
                sel_blank = hi_zero && (k > 0);
            end
        end
    end

    assign seg_raw = sel_blank ? 7'h00 : decode(sel_nib);
`else
    assign seg_raw = decode(sel_nib);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            wrap     <= 1'b0;
            ld_ready <= 1'b0;
            seg      <= SEG_OFF;
            dig_sel  <= DIG_OFF;
            presc    <= '0;
            scan_cnt <= '0;
            scan_idx <= '0;
        end else begin
            ld_ready <= 1'b1;
            wrap     <= 1'b0;
            if (load) begin
                count <= ld_clamped;
                presc <= '0;
            end else if (en) begin
                if (tick) begin
                    count <= step_cnt;
                    wrap  <= carry_out;
                    presc <= '0;
                end else begin
                    presc <= presc + 1'b1;
                end
            end

            if (scan_cnt == SW'(SCAN_CYCLES - 1)) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end

            seg     <= (SEG_INV != 0) ? ~seg_raw : seg_raw;
            dig_sel <= (SEG_INV != 0) ? ~onehot : onehot;
        end
    end

endmodule

// File: tb/tb_seg_bcd_scan_counter.sv
// Bench for seg_bcd_scan_counter: decimal-arithmetic reference model checked every cycle,
// plus a table of load/count vectors and hand sequences for load/tick collision, hold and scan.
module tb_seg_bcd_scan_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       ld_valid;
    logic       ld_ready;
    logic [7:0] ld_data;
    logic [7:0] count;
    logic       wrap;
    logic [6:0] seg;
    logic [1:0] dig_sel;

    int n_cmp = 0;
    int n_err = 0;

    seg_bcd_scan_counter #(
        .NUM_DIGITS (2),
        .TICK_CYCLES(4),
        .SCAN_CYCLES(2),
        .SEG_INV    (0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .up      (up),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_data (ld_data),
        .count   (count),
        .wrap    (wrap),
        .seg     (seg),
        .dig_sel (dig_sel)
    );

    always #5 clk = ~clk;

    logic [6:0] lut [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference state: value held as a plain integer 0..99.
    int         m_val, m_presc, m_scnt, m_idx;
    bit         m_wrap, m_rdy;
    logic [6:0] m_seg;
    logic [1:0] m_dig;

    function automatic int clamp(input logic [7:0] x);
        int lo, hi;
        lo = (x[3:0] > 4'd9) ? 9 : int'(x[3:0]);
        hi = (x[7:4] > 4'd9) ? 9 : int'(x[7:4]);
        return hi * 10 + lo;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model();
        int d;
        bit blank;
        if (!rst_n) begin
            m_val = 0; m_presc = 0; m_scnt = 0; m_idx = 0;
            m_wrap = 0; m_rdy = 0; m_seg = 7'h00; m_dig = 2'b00;
        end else begin
            d = (m_idx == 0) ? m_val % 10 : m_val / 10;
            blank = 0;
`ifdef SEG_LZ_BLANK_EN
            blank = (m_idx == 1) && (m_val / 10 == 0);
`endif
            m_seg  = blank ? 7'h00 : lut[d];
            m_dig  = (m_idx == 0) ? 2'b01 : 2'b10;
            m_wrap = 0;
            if (ld_valid && m_rdy) begin
                m_val   = clamp(ld_data);
                m_presc = 0;
            end else if (en) begin
                if (m_presc == 3) begin
                    m_wrap  = up ? (m_val == 99) : (m_val == 0);
                    m_val   = up ? (m_val + 1) % 100 : (m_val + 99) % 100;
                    m_presc = 0;
                end else begin
                    m_presc++;
                end
            end
            if (m_scnt == 1) begin
                m_scnt = 0;
                m_idx  = (m_idx + 1) % 2;
            end else begin
                m_scnt++;
            end
            m_rdy = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model();
        #1;
        chk("m_count", 32'(count), 32'(to_bcd(m_val)));
        chk("m_wrap", 32'(wrap), 32'(m_wrap));
        chk("m_ld_ready", 32'(ld_ready), 32'(m_rdy));
        chk("m_seg", 32'(seg), 32'(m_seg));
        chk("m_dig_sel", 32'(dig_sel), 32'(m_dig));
    endtask

    task automatic do_load(input logic [7:0] v);
        ld_data  = v;
        ld_valid = 1'b1;
        step();
        ld_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0] ld;
        bit         up;
        int         ticks;
        logic [7:0] exp_cnt;
        bit         exp_wrap;
    } vec_t;

    vec_t vt [8];

    initial begin
        vt[0] = '{8'h09, 1'b1, 1, 8'h10, 1'b0};
        vt[1] = '{8'h99, 1'b1, 1, 8'h00, 1'b1};
        vt[2] = '{8'h00, 1'b0, 1, 8'h99, 1'b1};
        vt[3] = '{8'h3C, 1'b1, 0, 8'h39, 1'b0};
        vt[4] = '{8'hFF, 1'b1, 0, 8'h99, 1'b0};
        vt[5] = '{8'h42, 1'b0, 1, 8'h41, 1'b0};
        vt[6] = '{8'h19, 1'b1, 2, 8'h21, 1'b0};
        vt[7] = '{8'h98, 1'b1, 3, 8'h01, 1'b0};

        rst_n = 1'b0; en = 1'b0; up = 1'b1; ld_valid = 1'b0; ld_data = 8'h00;
        repeat (3) step();
        chk("rst_count", 32'(count), 32'h00);
        chk("rst_seg", 32'(seg), 32'h00);
        chk("rst_dig_sel", 32'(dig_sel), 32'h0);
        chk("rst_ld_ready", 32'(ld_ready), 32'h0);
        rst_n = 1'b1;
        step();
        chk("release_ld_ready", 32'(ld_ready), 32'h1);

        for (int i = 0; i < 8; i++) begin
            en = 1'b1;
            up = vt[i].up;
            do_load(vt[i].ld);
            repeat (4 * vt[i].ticks) step();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].exp_cnt));
            chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vt[i].exp_wrap));
        end

        // Wrap lasts one cycle; en=0 freezes the count.
        up = 1'b1; en = 1'b1;
        do_load(8'h99);
        repeat (4) step();
        chk("wrap_pulse", 32'(wrap), 32'h1);
        step();
        chk("wrap_drop", 32'(wrap), 32'h0);
        up = 1'b0;
        do_load(8'h00);
        repeat (4) step();
        chk("down_wrap_cnt", 32'(count), 32'h99);
        en = 1'b0;
        repeat (20) step();
        chk("hold_cnt", 32'(count), 32'h99);

        // Load on the tick cycle wins and restarts the prescaler.
        en = 1'b1; up = 1'b1;
        do_load(8'h00);
        repeat (3) step();
        do_load(8'h55);
        chk("collide_cnt", 32'(count), 32'h55);
        chk("collide_wrap", 32'(wrap), 32'h0);
        repeat (3) step();
        chk("collide_hold", 32'(count), 32'h55);
        step();
        chk("collide_next", 32'(count), 32'h56);

        en = 1'b0;
        do_load(8'h42);
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("scan42_onehot", 32'(dig_sel == 2'b01 || dig_sel == 2'b10), 32'h1);
            chk("scan42_seg", 32'(seg), (dig_sel == 2'b01) ? 32'h5B : 32'h66);
        end

        do_load(8'h05);
        step();
        for (int i = 0; i < 4; i++) begin
            step();
`ifdef SEG_LZ_BLANK_EN
            chk("lz05_seg", 32'(seg), (dig_sel == 2'b01) ? 32'h6D : 32'h00);
`else
            chk("lz05_seg", 32'(seg), (dig_sel == 2'b01) ? 32'h6D : 32'h3F);
`endif
        end

        for (int i = 0; i < 400; i++) begin
            rst_n    = ($urandom % 50) != 0;
            en       = ($urandom % 4) != 0;
            up       = 1'($urandom % 2);
            ld_valid = ($urandom % 16) == 0;
            ld_data  = 8'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
